// File: rtl/pe_stream_driver.sv
// rtl/pe_stream_driver.sv - head/count/stream sequencer feeding one MAC processing element
// Define PE_DRV_TIMEOUT_EN to add the WAIT-state watchdog that drives err.
module pe_stream_driver #(
   parameter int DATA_W      = 32,
   parameter int CNT_W       = 10,
   parameter int ADDR_W      = 10,
   parameter int TIMEOUT_CYC = 64
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              start,
   input  logic [CNT_W-1:0]  n_len,
   input  logic [DATA_W-1:0] bias,
   input  logic [ADDR_W-1:0] w_base,
   input  logic [ADDR_W-1:0] x_base,
   output logic              mem_rd_en,
   output logic [ADDR_W-1:0] w_addr,
   output logic [ADDR_W-1:0] x_addr,
   input  logic [DATA_W-1:0] w_rdata,
   input  logic [DATA_W-1:0] x_rdata,
   output logic              pe_head,
   output logic [DATA_W-1:0] pe_w,
   output logic [DATA_W-1:0] pe_x_in,
   output logic [DATA_W-1:0] pe_b,
   output logic [CNT_W-1:0]  pe_count,
   input  logic [DATA_W-1:0] pe_result,
   input  logic              pe_done,
   output logic [DATA_W-1:0] result,
   output logic              result_valid,
   output logic              busy,
   output logic              err
);
   typedef enum logic [2:0] {S_IDLE, S_LOAD, S_HEAD, S_STREAM, S_WAIT, S_RESULT} state_t;

   localparam logic [CNT_W-1:0]  C_ONE = 1;
   localparam logic [CNT_W:0]    C_TWO = 2;
   localparam logic [ADDR_W-1:0] A_ONE = 1;
   localparam logic [ADDR_W-1:0] A_TWO = 2;

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  n_q, k_q;
   logic [CNT_W:0]    k_plus2;
   logic [DATA_W-1:0] bias_q, w_q, x_q, result_q;
   logic [ADDR_W-1:0] w_base_q, x_base_q, rd_idx;
   logic              done_seen_q, done_hit, timeout_hit;

   assign k_plus2 = {1'b0, k_q} + C_TWO;

   // The PE clears its stale done flag on the header edge, so done only counts from element 1 on.
   assign done_hit = pe_done && !done_seen_q &&
                     ((state_q == S_STREAM && k_q != '0) || state_q == S_WAIT);

   always_comb begin
      state_d   = state_q;
      mem_rd_en = 1'b0;
      rd_idx    = '0;
      pe_head   = 1'b0;
      pe_w      = '0;
      pe_x_in   = '0;
      pe_count  = '0;
      case (state_q)
         S_IDLE: if (start && n_len != '0) state_d = S_LOAD;
         S_LOAD: begin
            mem_rd_en = 1'b1;
            state_d   = S_HEAD;
         end
         S_HEAD: begin
            pe_head   = 1'b1;
            pe_x_in   = DATA_W'(n_q);
            mem_rd_en = (n_q > C_ONE);
            rd_idx    = A_ONE;
            state_d   = S_STREAM;
         end
         S_STREAM: begin
            pe_w      = w_q;
            pe_x_in   = x_q;
            pe_count  = k_q;
            mem_rd_en = (k_plus2 < {1'b0, n_q});
            rd_idx    = ADDR_W'(k_q) + A_TWO;
            if (k_q == n_q - C_ONE) state_d = S_WAIT;
         end
         S_WAIT: begin
            if (done_seen_q || done_hit) state_d = S_RESULT;
            else if (timeout_hit)        state_d = S_RESULT;
         end
         S_RESULT: state_d = S_IDLE;
         default:  state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q     <= S_IDLE;
         n_q         <= '0;
         k_q         <= '0;
         bias_q      <= '0;
         w_base_q    <= '0;
         x_base_q    <= '0;
         w_q         <= '0;
         x_q         <= '0;
         result_q    <= '0;
         done_seen_q <= 1'b0;
      end else begin
         state_q <= state_d;
         if (state_q == S_IDLE && state_d == S_LOAD) begin
            n_q         <= n_len;
            bias_q      <= bias;
            w_base_q    <= w_base;
            x_base_q    <= x_base;
            done_seen_q <= 1'b0;
         end
         if (state_q == S_HEAD || state_q == S_STREAM) begin
            w_q <= w_rdata;
            x_q <= x_rdata;
         end
         if (state_q == S_HEAD)        k_q <= '0;
         else if (state_q == S_STREAM) k_q <= k_q + C_ONE;
         if (done_hit) begin
            result_q    <= pe_result;
            done_seen_q <= 1'b1;
         end
      end
   end

   assign w_addr       = mem_rd_en ? w_base_q + rd_idx : '0;
   assign x_addr       = mem_rd_en ? x_base_q + rd_idx : '0;
   assign busy         = (state_q != S_IDLE);
   assign pe_b         = busy ? bias_q : '0;
   assign result       = result_q;
   assign result_valid = (state_q == S_RESULT);

`ifdef PE_DRV_TIMEOUT_EN
   localparam int              WD_W    = $clog2(TIMEOUT_CYC + 1);
   localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYC - 1);
   localparam logic [WD_W-1:0] WD_ONE  = 1;
   logic [WD_W-1:0] wd_q;
   logic            err_q;

   assign timeout_hit = (state_q == S_WAIT) && !done_seen_q && !pe_done && (wd_q == WD_LAST);

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         wd_q  <= '0;
         err_q <= 1'b0;
      end else begin
         if (state_q != S_WAIT) wd_q <= '0;
         else                   wd_q <= wd_q + WD_ONE;
         if (state_q == S_IDLE) err_q <= 1'b0;
         else if (timeout_hit)  err_q <= 1'b1;
      end
   end

   assign err = err_q && (state_q == S_RESULT);
`else
   assign timeout_hit = 1'b0;
   assign err         = result_valid && (TIMEOUT_CYC < 0);
`endif
endmodule

// File: tb/tb_pe_stream_driver.sv
// tb/tb_pe_stream_driver.sv - randomized self-checking bench for pe_stream_driver
module tb_pe_stream_driver;
   localparam int TIMEOUT = 64;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic [9:0]  n_len = '0;
   logic [31:0] bias = '0;
   logic [9:0]  w_base = '0, x_base = '0;
   logic        mem_rd_en;
   logic [9:0]  w_addr, x_addr;
   logic [31:0] w_rdata = '0, x_rdata = '0;
   logic        pe_head;
   logic [31:0] pe_w, pe_x_in, pe_b;
   logic [9:0]  pe_count;
   logic [31:0] pe_result = '0;
   logic        pe_done = 1'b0;
   logic [31:0] result;
   logic        result_valid, busy, err;

   logic [31:0] wmem [0:1023];
   logic [31:0] xmem [0:1023];
   bit          done_sched [0:255];
   logic [31:0] res_sched [0:255];
   logic [31:0] exp_result = '0;
   int          total = 0;
   int          bad = 0;

   pe_stream_driver #(.DATA_W(32), .CNT_W(10), .ADDR_W(10), .TIMEOUT_CYC(TIMEOUT)) dut (
      .clock(clock), .reset(reset), .start(start), .n_len(n_len), .bias(bias),
      .w_base(w_base), .x_base(x_base), .mem_rd_en(mem_rd_en), .w_addr(w_addr),
      .x_addr(x_addr), .w_rdata(w_rdata), .x_rdata(x_rdata), .pe_head(pe_head),
      .pe_w(pe_w), .pe_x_in(pe_x_in), .pe_b(pe_b), .pe_count(pe_count),
      .pe_result(pe_result), .pe_done(pe_done), .result(result),
      .result_valid(result_valid), .busy(busy), .err(err)
   );

   always #5 clock = ~clock;

   always @(posedge clock) begin
      if (mem_rd_en) begin
         w_rdata <= wmem[w_addr];
         x_rdata <= xmem[x_addr];
      end
   end

   task automatic clear_sched;
      for (int i = 0; i < 256; i++) begin
         done_sched[i] = 1'b0;
         res_sched[i]  = $urandom;
      end
   endtask

   // Expected trace of one operation started at offset 0 (the current cycle):
   // read j at offset 1+j, header at 2, element k at 3+k, result one cycle after
   // the later of offset 3+N and the first pe_done seen at offset >= 4.
   task automatic run_op(input int n, input logic [9:0] wb, input logic [9:0] xb,
                         input logic [31:0] bs, input bit pokes);
      int d, r, k;
      bit to, e_rd, e_rv;
      logic [31:0] e_w, e_x;
      logic [9:0]  e_cnt;
      d = -1;
      for (int i = 4; i < 256; i++) if (d < 0 && done_sched[i]) d = i;
      to = (d < 0);
      if (to) r = 3 + n + TIMEOUT;
      else    r = (((3 + n) > d) ? (3 + n) : d) + 1;
      if (!to) exp_result = res_sched[d];
      start = 1'b1; n_len = 10'(n); w_base = wb; x_base = xb; bias = bs;
      pe_done = done_sched[0]; pe_result = res_sched[0];
      for (int off = 1; off <= r; off++) begin
         @(posedge clock); #1;
         start = 1'b0;
         if (pokes && (off % 3 == 0) && off < r) begin
            start = 1'b1; n_len = 10'($urandom_range(1, 1023)); w_base = 10'($urandom);
         end
         pe_done = done_sched[off]; pe_result = res_sched[off];
         e_rd = (off <= n); e_rv = (off == r);
         e_w = '0; e_x = '0; e_cnt = '0;
         if (off == 2) e_x = 32'(n);
         if (off >= 3 && off <= 2 + n) begin
            k = off - 3;
            e_w = wmem[wb + 10'(k)]; e_x = xmem[xb + 10'(k)]; e_cnt = 10'(k);
         end
         total++; if (busy !== 1'b1) begin bad++; $display("FAIL busy off=%0d got=%b want=1", off, busy); end
         total++; if (mem_rd_en !== e_rd) begin bad++; $display("FAIL rd_en off=%0d got=%b want=%b", off, mem_rd_en, e_rd); end
         if (e_rd) begin
            total++;
            if ({w_addr, x_addr} !== {wb + 10'(off - 1), xb + 10'(off - 1)}) begin
               bad++; $display("FAIL addr off=%0d got=%h/%h want=%h/%h", off, w_addr, x_addr, wb + 10'(off - 1), xb + 10'(off - 1));
            end
         end
         total++; if (pe_head !== (off == 2)) begin bad++; $display("FAIL head off=%0d got=%b", off, pe_head); end
         total++;
         if (pe_w !== e_w || pe_x_in !== e_x) begin
            bad++; $display("FAIL operands off=%0d got=%h/%h want=%h/%h", off, pe_w, pe_x_in, e_w, e_x);
         end
         total++; if (pe_count !== e_cnt) begin bad++; $display("FAIL count off=%0d got=%0d want=%0d", off, pe_count, e_cnt); end
         total++; if (pe_b !== bs) begin bad++; $display("FAIL bias off=%0d got=%h want=%h", off, pe_b, bs); end
         total++; if (result_valid !== e_rv) begin bad++; $display("FAIL rvalid off=%0d got=%b want=%b", off, result_valid, e_rv); end
         if (e_rv) begin
            total++; if (result !== exp_result) begin bad++; $display("FAIL result got=%h want=%h", result, exp_result); end
            total++; if (err !== to) begin bad++; $display("FAIL err got=%b want=%b", err, to); end
         end
      end
      @(posedge clock); #1;
      start = 1'b0; pe_done = 1'b0;
      total++;
      if (busy !== 1'b0 || result_valid !== 1'b0 || result !== exp_result) begin
         bad++; $display("FAIL post_op got busy=%b rv=%b res=%h want 0/0/%h", busy, result_valid, result, exp_result);
      end
   endtask

   task automatic idle(input int c);
      for (int i = 0; i < c; i++) begin
         @(posedge clock); #1;
         total++; if (busy !== 1'b0) begin bad++; $display("FAIL idle_busy got=%b want=0", busy); end
      end
   endtask

   task automatic check_all_zero(input string name);
      total++;
      if ({mem_rd_en, w_addr, x_addr, pe_head, pe_w, pe_x_in, pe_b, pe_count,
           result, result_valid, busy, err} !== '0) begin
         bad++; $display("FAIL %s got busy=%b rd=%b w=%h x=%h b=%h res=%h want all 0", name, busy, mem_rd_en, pe_w, pe_x_in, pe_b, result);
      end
   endtask

   task automatic test_reset;
      @(posedge clock); #1;
      check_all_zero("reset_state");
      reset = 1'b0;
      idle(2);
   endtask

   task automatic test_basic;
      for (int i = 0; i < 4; i++) begin
         wmem[10'h040 + 10'(i)] = 32'h3F800000;
         xmem[10'h080 + 10'(i)] = 32'h40000000;
      end
      clear_sched();
      done_sched[7] = 1'b1; res_sched[7] = 32'h41000000;
      run_op(4, 10'h040, 10'h080, 32'h3F000000, 1'b0);
      total++; if (result !== 32'h41000000) begin bad++; $display("FAIL basic_result got=%h want=41000000", result); end
   endtask

   task automatic test_single;
      clear_sched();
      done_sched[$urandom_range(4, 8)] = 1'b1;
      run_op(1, 10'($urandom), 10'($urandom), $urandom, 1'b0);
   endtask

   task automatic test_stale_done;
      clear_sched();
      for (int i = 0; i < 4; i++) done_sched[i] = 1'b1;
      done_sched[8] = 1'b1;
      done_sched[9] = 1'b1;
      run_op(4, 10'($urandom), 10'($urandom), $urandom, 1'b0);
   endtask

   task automatic test_wrap;
      clear_sched();
      done_sched[9] = 1'b1;
      run_op(4, 10'h3FE, 10'h3FF, $urandom, 1'b0);
   endtask

   task automatic test_start_while_busy;
      clear_sched();
      done_sched[10] = 1'b1;
      run_op(5, 10'($urandom), 10'($urandom), $urandom, 1'b1);
   endtask

   task automatic test_back_to_back;
      for (int j = 0; j < 3; j++) begin
         clear_sched();
         done_sched[$urandom_range(4, 12)] = 1'b1;
         run_op($urandom_range(1, 6), 10'($urandom), 10'($urandom), $urandom, 1'b0);
      end
   endtask

   task automatic test_random;
      int n, d;
      for (int j = 0; j < 20; j++) begin
         n = $urandom_range(1, 16);
         clear_sched();
         for (int i = 0; i < 4; i++) done_sched[i] = 1'($urandom_range(0, 1));
         d = $urandom_range(4, n + 8);
         done_sched[d] = 1'b1;
         for (int i = d + 1; i < 256; i++) done_sched[i] = 1'($urandom_range(0, 1));
         run_op(n, 10'($urandom), 10'($urandom), $urandom, 1'($urandom_range(0, 1)));
         idle($urandom_range(0, 2));
      end
   endtask

   task automatic test_reset_mid;
      clear_sched();
      start = 1'b1; n_len = 10'd6; w_base = 10'($urandom); x_base = 10'($urandom); bias = $urandom;
      for (int off = 1; off <= 5; off++) begin
         @(posedge clock); #1;
         start = 1'b0;
      end
      total++; if (pe_count !== 10'd2) begin bad++; $display("FAIL mid_stream got count=%0d want=2", pe_count); end
      #2 reset = 1'b1;
      #1 check_all_zero("async_reset");
      @(posedge clock); #1;
      reset = 1'b0; pe_done = 1'b1; pe_result = $urandom;
      for (int c = 0; c < 12; c++) begin
         @(posedge clock); #1;
         total++;
         if (result_valid !== 1'b0 || busy !== 1'b0) begin
            bad++; $display("FAIL after_reset got rv=%b busy=%b want 0/0", result_valid, busy);
         end
      end
      pe_done = 1'b0;
      exp_result = '0;
      check_all_zero("after_reset_idle");
   endtask

`ifdef PE_DRV_TIMEOUT_EN
   task automatic test_timeout;
      clear_sched();
      run_op(3, 10'($urandom), 10'($urandom), $urandom, 1'b0);
   endtask
`endif

   initial begin
      for (int i = 0; i < 1024; i++) begin
         wmem[i] = $urandom;
         xmem[i] = $urandom;
      end
      test_reset();
      test_basic();
      test_single();
      test_stale_done();
      test_wrap();
      test_start_while_busy();
      test_back_to_back();
      test_random();
      test_reset_mid();
      test_back_to_back();
`ifdef PE_DRV_TIMEOUT_EN
      test_timeout();
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/pe_stream_driver.md
# pe_stream_driver

Sequencer that feeds one `pro_ele`-style floating-point MAC processing element. On `start` it sends a header beat carrying the element count, then streams N weight/input pairs fetched from two synchronous-read memories, and returns the PE's result with a one-cycle valid pulse. It is the transmit side of the head/count/stream protocol that the processing element consumes. It sits between the layer controller and each PE instance.

## Interface
Parameters:
- `DATA_W`, 32: word width (IEEE-754 single)
- `CNT_W`, 10: element-count width
- `ADDR_W`, 10: memory address width
- `TIMEOUT_CYC`, 64: watchdog limit in cycles (only with `PE_DRV_TIMEOUT_EN`)

Ports:
- `clock` in 1: single clock, rising edge
- `reset` in 1: asynchronous, active-high
- `start` in 1: begin an operation (sampled only in IDLE)
- `n_len` in CNT_W: element count N
- `bias` in DATA_W: bias word
- `w_base`, `x_base` in ADDR_W: memory base addresses
- `mem_rd_en` out 1: read strobe, shared by both memories
- `w_addr`, `x_addr` out ADDR_W: read addresses
- `w_rdata`, `x_rdata` in DATA_W: read data, valid one cycle after `mem_rd_en`
- `pe_head` out 1: header beat to the PE
- `pe_w`, `pe_x_in`, `pe_b` out DATA_W: PE operands
- `pe_count` out CNT_W: index of the current element
- `pe_result` in DATA_W: PE output (`pe_out`)
- `pe_done` in 1: PE done flag
- `result` out DATA_W: captured PE result
- `result_valid` out 1: one-cycle pulse
- `busy` out 1: high in every state except IDLE
- `err` out 1: timeout flag, qualified by `result_valid` (tied 0 without the macro)

## Operation
- Reset value of every output and register is 0. State goes to IDLE.
- States: IDLE, LOAD, HEAD, STREAM, WAIT, RESULT.
- **IDLE:**
  - `start`=1 with `n_len`≠0: latch N, `bias`, and both bases; go to LOAD.
  - `start` with `n_len`=0 is ignored.
  - `start` outside IDLE is ignored.
- **LOAD (1 cycle):** `mem_rd_en`=1, addresses = base+0.
- **HEAD (1 cycle):**
  - `pe_head`=1, `pe_x_in`={zero-extend, N}, `pe_w`=0.
  - Issue address base+1 if N>1.
- **STREAM (N cycles, k=0..N-1):**
  - `pe_w`/`pe_x_in` = element k, registered from rdata.
  - `pe_count`=k.
  - Read issued for k+2 while k+2<N.
  - After k=N-1, go to WAIT.
- **WAIT:**
  - Hold `pe_w`/`pe_x_in` at 0.
  - Stay until `done_seen` is set, then go to RESULT.
- **RESULT (1 cycle):** `result_valid`=1, then go to IDLE.
- `pe_b` = latched bias from LOAD through RESULT; 0 in IDLE.
- **Done capture:**
  - `pe_done` is ignored through the first STREAM cycle, because the PE clears its stale flag on the header edge.
  - From the second STREAM cycle onward, the first cycle with `pe_done`=1 latches `result`←`pe_result` and sets `done_seen`.
  - Later `pe_done` cycles in the same operation do not re-latch.
- Addresses = base+k modulo 2^ADDR_W; wrap is legal.
- `result` holds its value until the next capture.
- `reset` mid-operation: outputs drop to 0 immediately (asynchronous), state goes to IDLE, and the operation is abandoned with no `result_valid`.

## Timing
- `start` sampled at cycle S.
- LOAD at S+1; HEAD at S+2; element k on `pe_w`/`pe_x_in` at S+3+k.
- No gap between the header beat and element 0, or between elements.
- Memory read latency is fixed at 1 cycle.
- `mem_rd_en` is high for exactly N cycles per operation.
- `result_valid` occurs no earlier than S+3+N, and one cycle after the later of (stream end, first qualifying `pe_done`).
- Back-to-back operations: `start` is accepted in the cycle after RESULT.

## Configuration
- **`PE_DRV_TIMEOUT_EN` defined:**
  - A watchdog counts cycles spent in WAIT.
  - When the count reaches `TIMEOUT_CYC` without `pe_done`, go to RESULT with `err`=1 and `result` unchanged.
  - The counter clears on entering WAIT.
- **`PE_DRV_TIMEOUT_EN` undefined:**
  - WAIT lasts indefinitely.
  - `err` is tied 0.

## Test plan
- **Basic operation.**
  - Stimulus: N=4, memories hold w=0x3F800000 and x=0x40000000; a PE stub returns 0x41000000 with `pe_done` at S+7.
  - Required: header at S+2 with `pe_x_in`=0x00000004; elements at S+3..S+6; `result_valid` at S+8 with `result`=0x41000000.
- **Single element.**
  - Stimulus: N=1.
  - Required: exactly one `mem_rd_en` cycle (S+1); element 0 at S+3; `pe_count`=0.
- **Stale done.**
  - Stimulus: `pe_done` held high from the previous operation through S+3, low at S+4, high again at S+8 with a new value.
  - Required: only the S+8 value is captured.
- **Address wrap.**
  - Stimulus: `w_base`=0x3FE, N=4.
  - Required: `w_addr` sequence 0x3FE, 0x3FF, 0x000, 0x001.
- **Reset and busy handling.**
  - Stimulus: assert `reset` during STREAM, then deassert; in a separate run, pulse `start` while `busy`.
  - Required: after reset, all outputs 0 and no `result_valid`; the `start` while `busy` is ignored.
- **Timeout (`PE_DRV_TIMEOUT_EN` only).**
  - Stimulus: `pe_done` never asserted, `TIMEOUT_CYC`=64.
  - Required: `result_valid` and `err` both 1 after 64 WAIT cycles; `result` unchanged.
